// File: rtl/dds_waveform_gen_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg
// Shared definitions for the DDS waveform core.
//   wave_e      : waveform select encoding carried on wave_sel
//   LUT_DEPTH   : entries in the quarter-wave sine ROM
//   MIDSCALE()  : offset-binary zero level for a given DAC width
// -----------------------------------------------------------------------------
package dds_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_e;

  localparam int LUT_DEPTH = 64;

  // Offset-binary mid-scale code, 2^(aw-1).
  function automatic int unsigned MIDSCALE(input int unsigned aw);
    return 32'd1 << (aw - 1);
  endfunction

endpackage

// File: rtl/dds_waveform_gen_if.sv
// -----------------------------------------------------------------------------
// dds_waveform_gen_if
// Bus between the sample-rate generator / control side and the DDS core.
//   sample_in : square wave, rising edge = sample tick
//   freq_word : phase increment per tick
//   freq_load : one-cycle pulse capturing freq_word and wave_sel
//   wave_sel  : waveform select (dds_pkg::wave_e encoding)
//   dac_data  : offset-binary sample
//   dac_valid : one-cycle strobe marking a new dac_data
// master = control/stimulus side, slave = DDS core.
// -----------------------------------------------------------------------------
interface dds_waveform_gen_if #(
  parameter int PHASE_W = 32,
  parameter int AMP_W   = 10
);
  logic               sample_in;
  logic [PHASE_W-1:0] freq_word;
  logic               freq_load;
  logic [1:0]         wave_sel;
  logic [AMP_W-1:0]   dac_data;
  logic               dac_valid;

  modport master (
    output sample_in, freq_word, freq_load, wave_sel,
    input  dac_data, dac_valid
  );

  modport slave (
    input  sample_in, freq_word, freq_load, wave_sel,
    output dac_data, dac_valid
  );
endinterface

// File: rtl/dds_sine_quarter_lut.sv
// -----------------------------------------------------------------------------
// dds_sine_quarter_lut
// Quarter-wave sine magnitude ROM with synchronous read.
//   clk   : clock
//   rd_en : read enable; mag updates only when set
//   addr  : mirrored quarter-wave address
//   mag   : registered magnitude, round(511*sin(pi/2*(i+0.5)/64))
// The half-LSB offset in the sample points keeps the table symmetric so a
// bitwise-inverted address mirrors the quarter exactly.
// -----------------------------------------------------------------------------
module dds_sine_quarter_lut
  import dds_pkg::*;
#(
  parameter int AW = 6,
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] mag
);

  localparam logic [DW-1:0] SINE_ROM [LUT_DEPTH] = '{
    9'd6,   9'd19,  9'd31,  9'd44,  9'd56,  9'd69,  9'd81,  9'd94,
    9'd106, 9'd118, 9'd130, 9'd142, 9'd154, 9'd166, 9'd178, 9'd190,
    9'd201, 9'd213, 9'd224, 9'd235, 9'd246, 9'd257, 9'd268, 9'd279,
    9'd289, 9'd299, 9'd309, 9'd319, 9'd329, 9'd338, 9'd348, 9'd357,
    9'd366, 9'd374, 9'd383, 9'd391, 9'd399, 9'd407, 9'd414, 9'd421,
    9'd428, 9'd435, 9'd441, 9'd448, 9'd454, 9'd459, 9'd465, 9'd470,
    9'd474, 9'd479, 9'd483, 9'd487, 9'd491, 9'd494, 9'd497, 9'd500,
    9'd502, 9'd505, 9'd506, 9'd508, 9'd509, 9'd510, 9'd511, 9'd511
  };

  always_ff @(posedge clk) begin
    if (rd_en) begin
      mag <= SINE_ROM[addr];
    end
  end

endmodule

// File: rtl/dds_waveform_gen.sv
// -----------------------------------------------------------------------------
// dds_waveform_gen
// DDS core: each rising edge of bus.sample_in advances a phase accumulator by
// the active frequency word and produces one offset-binary DAC sample
// (sine / square / triangle / sawtooth) three clocks later.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : dds_waveform_gen_if.slave (sample_in, freq_word, freq_load,
//           wave_sel in; dac_data, dac_valid out)
// Pipeline: edge n phase update, edge n+1 stage 1 (top phase bits, select,
// ROM read), edge n+2 dac_data/dac_valid.
// -----------------------------------------------------------------------------
module dds_waveform_gen
  import dds_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int AMP_W   = 10,
  parameter int LUT_AW  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  dds_waveform_gen_if.slave bus
);

  logic               sample_d;
  logic               tick;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] freq_pending;
  logic [PHASE_W-1:0] freq_active;
  wave_e              sel_pending;
  wave_e              sel_active;
  wave_e              sel_s1;
  logic               valid_s0;
  logic               valid_s1;
  // Top AMP_W+1 phase bits: MSB is the half-cycle sign, the rest feed
  // triangle directly and sawtooth after dropping the LSB.
  logic [AMP_W:0]     top_s1;
  logic [LUT_AW-1:0]  idx;
  logic [LUT_AW-1:0]  lut_addr;
  logic [AMP_W-2:0]   lut_mag;
  logic [AMP_W-1:0]   wave_next;
  logic [AMP_W-1:0]   dac_data_reg;
  logic               dac_valid_reg;

  assign tick = bus.sample_in & ~sample_d;

  // Odd quadrants run the quarter-wave backwards.
  assign idx      = phase[PHASE_W-3 -: LUT_AW];
  assign lut_addr = phase[PHASE_W-2] ? ~idx : idx;

  dds_sine_quarter_lut #(
    .AW (LUT_AW),
    .DW (AMP_W - 1)
  ) u_lut (
    .clk   (clk),
    .rd_en (valid_s0),
    .addr  (lut_addr),
    .mag   (lut_mag)
  );

  always_comb begin
    wave_next = dac_data_reg;
    case (sel_s1)
      // Positive half: midscale + m; negative half: (midscale-1) - m.
      WAVE_SINE:   wave_next = top_s1[AMP_W] ? {1'b0, ~lut_mag} : {1'b1, lut_mag};
      WAVE_SQUARE: wave_next = top_s1[AMP_W] ? '0 : '1;
      WAVE_TRI:    wave_next = top_s1[AMP_W] ? ~top_s1[AMP_W-1:0] : top_s1[AMP_W-1:0];
      WAVE_SAW:    wave_next = top_s1[AMP_W -: AMP_W];
      default:     wave_next = dac_data_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // sample_d starts high so a level already high at release is not a tick.
      sample_d      <= 1'b1;
      phase         <= '0;
      freq_pending  <= '0;
      freq_active   <= '0;
      sel_pending   <= WAVE_SINE;
      sel_active    <= WAVE_SINE;
      sel_s1        <= WAVE_SINE;
      valid_s0      <= 1'b0;
      valid_s1      <= 1'b0;
      top_s1        <= '0;
      dac_data_reg  <= AMP_W'(MIDSCALE(AMP_W));
      dac_valid_reg <= 1'b0;
    end else begin
      sample_d <= bus.sample_in;

      if (bus.freq_load) begin
        freq_pending <= bus.freq_word;
        sel_pending  <= wave_e'(bus.wave_sel);
      end

      // The accumulate uses the word that was active before this tick, so a
      // load coincident with a tick only lands one tick later.
      if (tick) begin
        freq_active <= freq_pending;
        sel_active  <= sel_pending;
        phase       <= phase + freq_active;
      end

      valid_s0 <= tick;
      valid_s1 <= valid_s0;
      if (valid_s0) begin
        top_s1 <= phase[PHASE_W-1 -: AMP_W+1];
        sel_s1 <= sel_active;
      end

      dac_valid_reg <= valid_s1;
      if (valid_s1) begin
        dac_data_reg <= wave_next;
      end
    end
  end

  assign bus.dac_data  = dac_data_reg;
  assign bus.dac_valid = dac_valid_reg;

endmodule

// File: doc/dds_waveform_gen.md
# dds_waveform_gen

DDS waveform core driven by the square-wave sample-rate generator. Each rising edge of the incoming square wave is one sample tick. On each tick the core advances a phase accumulator by a programmable frequency word and produces one DAC sample. The waveform is sine, square, triangle or sawtooth, output as unsigned offset-binary data with a one-cycle valid strobe for the DAC interface stage.

## Interface
- `PHASE_W`, 32: phase accumulator and frequency word width.
- `AMP_W`, 10: DAC sample width, unsigned offset-binary.
- `LUT_AW`, 6: quarter-wave sine LUT address width (64 entries).

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset; one clock; reset is asynchronous and active-low.
- `sample_in`  in  1: square wave from the rate generator, same clock domain and registered; a rising edge is a tick.
- `freq_word`  in  PHASE_W: phase increment per tick.
- `freq_load`  in  1: one-cycle pulse that captures `freq_word` and `wave_sel`.
- `wave_sel`  in  2: 0 sine, 1 square, 2 triangle, 3 sawtooth.
- `dac_data`  out  AMP_W: sample value.
- `dac_valid`  out  1: one-cycle strobe, asserted when `dac_data` is new.

## Operation
- **Reset values:** `phase` 0; `freq_pending`/`freq_active` 0; `sel_pending`/`sel_active` 0; `dac_data` = 2^(AMP_W-1) (512); `dac_valid` 0; pipeline valids 0; `sample_d` 1.
- **Edge detect:** `tick = sample_in & ~sample_d`, with `sample_d <= sample_in` every cycle.
  - `sample_d` resets to 1, so a high `sample_in` at reset release is not a tick. The first tick is the first genuine 0->1 transition.
- **Load:** `freq_load` writes the `*_pending` registers.
  - On each tick, `*_active <= *_pending`, and the accumulate uses the old `freq_active`. A newly loaded word therefore affects the phase from the second tick after load.
  - `freq_load` coincident with a tick: the tick copies the old pending values; the new values apply at the next tick.
- **Accumulate:** on a tick, `phase <= phase + freq_active`, modulo 2^PHASE_W, with silent wrap.
  - `freq_word = 0` freezes phase, but `dac_valid` still pulses every tick.
- **Waveform map** (`P` = phase, `q = P[PW-1:PW-2]`, `idx = P[PW-3 -: LUT_AW]`):
  - **Sine:** in q1 and q3, `idx' = ~idx`, otherwise `idx' = idx`; `m = LUT[idx']`. Output is `512 + m` for q0/q1 and `511 - m` for q2/q3.
    - `LUT[i] = round(511*sin(pi/2*(i+0.5)/64))`, 9 bits; `LUT[0] = 6`, `LUT[63] = 511`.
  - **Square:** `P[PW-1] ? 0 : 2^AMP_W-1`.
  - **Triangle:** `t = P[PW-2 -: AMP_W]`; output is `P[PW-1] ? ~t : t`.
  - **Sawtooth:** `P[PW-1 -: AMP_W]`.
- `wave_sel` travels through the pipeline alongside its phase, so a switch never mixes two waveforms in one sample.

## Timing
- Let edge n be the clock edge at which `tick` = 1 is sampled.
  - Edge n: phase updated.
  - Edge n+1: stage 1 registers quadrant, mirrored address and select.
  - Edge n+2: `dac_data` registered and `dac_valid` = 1 for exactly one cycle.
- Fixed latency: 3 cycles from tick to valid. The tick period is at least 2 cycles by construction; the default rate is one tick per 5000 clocks.
- `dac_data` holds its value between valids.
- Asserting reset mid-pipeline clears all valids immediately. No stale sample is emitted after release.

## Structure
- Package `dds_pkg`:
  - wave select constants `WAVE_SINE`/`WAVE_SQUARE`/`WAVE_TRI`/`WAVE_SAW`;
  - `MIDSCALE` function of AMP_W;
  - `LUT_DEPTH`.
- Sub-module `dds_sine_quarter_lut`: synchronous-read quarter-wave ROM (address in, registered magnitude out). Its one-cycle read is stage 1 -> stage 2. Sign/offset logic stays in the parent.

## Test plan
- Reset released with `sample_in` = 1, no edges: `dac_valid` stays 0 and `dac_data` = 512.
- Sine, `freq_word` = 2^30 loaded before the first tick, then four ticks:
  - the first tick adds 0 (active word not yet updated) and outputs 518;
  - the following ticks output 1023, 505, 0.
- Square, word 2^31, ticks 2–3: 0, then 1023. Check `dac_valid` is exactly 3 cycles after each tick and 1 cycle wide.
- Sawtooth, word 2^28: outputs step 64, 128, … 960, then wrap to 0.
- Triangle, word 2^29: outputs 256, 512, 768, 1023, 767. Also pulse `freq_load` with a new word and `wave_sel` on the tick cycle: the change appears only at the tick after next.
- Assert `rst_n` one cycle after a tick: no `dac_valid` appears; all outputs return to reset values.
